// File: rtl/otp_slot_scheduler.sv
// -----------------------------------------------------------------------------
// otp_slot_scheduler
//
// Ring-buffer scheduler sharing the per-block OTP RAM between the keystream
// generator (producer) and the SD transfer datapath (consumer). Free slots are
// handed to the generator one at a time. Filled slots are granted to the SD
// side one at a time, in the same order they were filled.
//
// Ports:
//   iclk, irst_n      clock, asynchronous active-low reset
//   ienable           level, permits new generation starts and new grants
//   inew_session      pulse, flushes all slots and restarts the OTP sequence
//   ogen_start        one-cycle pulse, generator fills slot osel_gen
//   onew_otp          high with the first ogen_start after reset/flush
//   osel_gen          slot being generated (held until the next start)
//   igen_done         pulse, generation of osel_gen finished
//   isd_req           level, SD side wants a filled slot
//   osd_grant         level, slot osel_sd is owned by the SD side
//   osel_sd           granted slot
//   isd_release       pulse, granted slot consumed
//   olevel            filled, unreleased slots (including the granted one)
//   ofull / oempty    olevel == RAM_BLOCKS / olevel == 0
//   oerr              sticky protocol error (cleared only by reset)
// -----------------------------------------------------------------------------
module otp_slot_scheduler #(
  parameter int RAM_BLOCKS = 8,
  parameter int SEL_W      = $clog2(RAM_BLOCKS)
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             ienable,
  input  logic             inew_session,
  output logic             ogen_start,
  output logic             onew_otp,
  output logic [SEL_W-1:0] osel_gen,
  input  logic             igen_done,
  input  logic             isd_req,
  output logic             osd_grant,
  output logic [SEL_W-1:0] osel_sd,
  input  logic             isd_release,
  output logic [SEL_W:0]   olevel,
  output logic             ofull,
  output logic             oempty,
  output logic             oerr
);

  localparam logic [SEL_W:0]   C_FULL    = (SEL_W+1)'(RAM_BLOCKS);
  localparam logic [SEL_W:0]   C_CNT_ONE = (SEL_W+1)'(1);
  localparam logic [SEL_W:0]   C_CNT_ZERO = (SEL_W+1)'(0);
  localparam logic [SEL_W-1:0] C_PTR_ONE = SEL_W'(1);
  localparam logic [SEL_W-1:0] C_PTR_ZERO = SEL_W'(0);

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_WAIT  = 2'd1,
    G_DRAIN = 2'd2
  } gen_state_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } sd_state_t;

  gen_state_t       r_gen_state, w_gen_state_nxt;
  sd_state_t        r_sd_state,  w_sd_state_nxt;

  logic [SEL_W-1:0] r_wp, w_wp_nxt;
  logic [SEL_W-1:0] r_rp, w_rp_nxt;
  logic [SEL_W:0]   r_cnt, w_cnt_nxt;
  logic             r_first_gen, w_first_gen_nxt;

  logic             r_gen_start;
  logic             r_new_otp;
  logic [SEL_W-1:0] r_sel_gen, w_sel_gen_nxt;
  logic             r_sd_grant;
  logic [SEL_W-1:0] r_sel_sd, w_sel_sd_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_err;

  logic             w_gen_go;
  logic             w_gen_inc;
  logic             w_sd_go;
  logic             w_sd_dec;
  logic             w_err_evt;

  // Event decode: starts, grants and accepted completions are all suppressed
  // by a flush; protocol errors are detected regardless.
  always_comb begin
    w_gen_go  = (r_gen_state == G_IDLE) && ienable && (r_cnt < C_FULL) && !inew_session;
    w_gen_inc = (r_gen_state == G_WAIT) && igen_done && !inew_session;
    w_sd_go   = (r_sd_state == S_IDLE) && ienable && isd_req && (r_cnt != C_CNT_ZERO) && !inew_session;
    w_sd_dec  = (r_sd_state == S_GRANT) && isd_release && !inew_session;
    w_err_evt = (igen_done && (r_gen_state == G_IDLE)) || (isd_release && (r_sd_state == S_IDLE));
  end

  // Generator FSM next state. A completion arriving together with a flush
  // closes out the in-flight generation, so no drain is needed.
  always_comb begin
    w_gen_state_nxt = r_gen_state;
    case (r_gen_state)
      G_IDLE: begin
        if (w_gen_go) begin
          w_gen_state_nxt = G_WAIT;
        end else begin
          w_gen_state_nxt = G_IDLE;
        end
      end
      G_WAIT: begin
        if (igen_done) begin
          w_gen_state_nxt = G_IDLE;
        end else if (inew_session) begin
          w_gen_state_nxt = G_DRAIN;
        end else begin
          w_gen_state_nxt = G_WAIT;
        end
      end
      G_DRAIN: begin
        if (igen_done) begin
          w_gen_state_nxt = G_IDLE;
        end else begin
          w_gen_state_nxt = G_DRAIN;
        end
      end
      default: w_gen_state_nxt = G_IDLE;
    endcase
  end

  // SD FSM next state; a flush revokes any grant.
  always_comb begin
    w_sd_state_nxt = r_sd_state;
    case (r_sd_state)
      S_IDLE: begin
        if (w_sd_go) begin
          w_sd_state_nxt = S_GRANT;
        end else begin
          w_sd_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (inew_session || isd_release) begin
          w_sd_state_nxt = S_IDLE;
        end else begin
          w_sd_state_nxt = S_GRANT;
        end
      end
      default: w_sd_state_nxt = S_IDLE;
    endcase
  end

  // Pointer, occupancy and slot-select next values.
  always_comb begin
    w_wp_nxt        = r_wp;
    w_rp_nxt        = r_rp;
    w_cnt_nxt       = r_cnt;
    w_first_gen_nxt = r_first_gen;
    w_sel_gen_nxt   = r_sel_gen;
    w_sel_sd_nxt    = r_sel_sd;
    if (inew_session) begin
      w_wp_nxt        = C_PTR_ZERO;
      w_rp_nxt        = C_PTR_ZERO;
      w_cnt_nxt       = C_CNT_ZERO;
      w_first_gen_nxt = 1'b1;
    end else begin
      if (w_gen_inc) begin
        w_wp_nxt = r_wp + C_PTR_ONE;
      end else begin
        w_wp_nxt = r_wp;
      end
      if (w_sd_dec) begin
        w_rp_nxt = r_rp + C_PTR_ONE;
      end else begin
        w_rp_nxt = r_rp;
      end
      // Simultaneous fill and release leave the occupancy unchanged.
      case ({w_gen_inc, w_sd_dec})
        2'b10:   w_cnt_nxt = r_cnt + C_CNT_ONE;
        2'b01:   w_cnt_nxt = r_cnt - C_CNT_ONE;
        default: w_cnt_nxt = r_cnt;
      endcase
      if (w_gen_go) begin
        w_first_gen_nxt = 1'b0;
        w_sel_gen_nxt   = r_wp;
      end else begin
        w_first_gen_nxt = r_first_gen;
        w_sel_gen_nxt   = r_sel_gen;
      end
      if (w_sd_go) begin
        w_sel_sd_nxt = r_rp;
      end else begin
        w_sel_sd_nxt = r_sel_sd;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_gen_state <= G_IDLE;
      r_sd_state  <= S_IDLE;
      r_wp        <= C_PTR_ZERO;
      r_rp        <= C_PTR_ZERO;
      r_cnt       <= C_CNT_ZERO;
      r_first_gen <= 1'b1;
      r_gen_start <= 1'b0;
      r_new_otp   <= 1'b0;
      r_sel_gen   <= C_PTR_ZERO;
      r_sd_grant  <= 1'b0;
      r_sel_sd    <= C_PTR_ZERO;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_gen_state <= w_gen_state_nxt;
      r_sd_state  <= w_sd_state_nxt;
      r_wp        <= w_wp_nxt;
      r_rp        <= w_rp_nxt;
      r_cnt       <= w_cnt_nxt;
      r_first_gen <= w_first_gen_nxt;
      r_gen_start <= w_gen_go;
      r_new_otp   <= w_gen_go && r_first_gen;
      r_sel_gen   <= w_sel_gen_nxt;
      r_sd_grant  <= (w_sd_state_nxt == S_GRANT);
      r_sel_sd    <= w_sel_sd_nxt;
      r_full      <= (w_cnt_nxt == C_FULL);
      r_empty     <= (w_cnt_nxt == C_CNT_ZERO);
      r_err       <= r_err || w_err_evt;
    end
  end

  assign ogen_start = r_gen_start;
  assign onew_otp   = r_new_otp;
  assign osel_gen   = r_sel_gen;
  assign osd_grant  = r_sd_grant;
  assign osel_sd    = r_sel_sd;
  assign olevel     = r_cnt;
  assign ofull      = r_full;
  assign oempty     = r_empty;
  assign oerr       = r_err;

endmodule
